// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared fetch-path types and constants for the IF/ID queue
package if_id_queue_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC = 32'd0;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH-entry fetch packet store, one write port, async read
module if_id_queue_mem
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  fetch_pkt_t       wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output fetch_pkt_t       rdata_o
);

    fetch_pkt_t mem_q [DEPTH];

    // storage is never reset; occupancy in the top decides what is meaningful
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID fetch queue with valid/ready handshakes and branch flush
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_pc,
    input  logic [WORD_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_instr,
    input  logic              out_ready,
    output logic [PTR_W:0]    count,
    output logic [31:0]       stall_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      stall_q, stall_d;
    logic             push, pop;
    occ_e             occ_q;
    fetch_pkt_t       wr_pkt, rd_pkt;

    // ready comes from registered count only, so a full queue refuses a push even during a pop
    assign in_ready  = count_q != FULL_CNT;
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_pc    = out_valid ? rd_pkt.pc : RESET_PC;
    assign out_instr = out_valid ? rd_pkt.instr : '0;
    assign count     = count_q;
    assign stall_cnt = stall_q;
    assign wr_pkt    = '{pc: in_pc, instr: in_instr};

    if_id_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(wr_pkt),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_pkt)
    );

    // next state: flush wins over push/pop, but never clears the stall counter
    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d  = flush ? '0 : (push && !pop) ? count_q + CNT_ONE : (pop && !push) ? count_q - CNT_ONE : count_q;
        stall_d  = stall_q + 32'(out_valid && !out_ready && !flush);
    end

    // pointer, occupancy and stall registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end

    // occupancy state machine, kept independently of count so the two can cross-check
    always_ff @(posedge clk or negedge rst)
        if (!rst) occ_q <= OCC_EMPTY;
        else if (flush) occ_q <= OCC_EMPTY;
        else
            case (occ_q)
                OCC_EMPTY:   if (push) occ_q <= OCC_PARTIAL;
                OCC_PARTIAL: if (push && !pop && count_q == FULL_CNT - CNT_ONE) occ_q <= OCC_FULL;
                             else if (pop && !push && count_q == CNT_ONE) occ_q <= OCC_EMPTY;
                OCC_FULL:    if (pop) occ_q <= OCC_PARTIAL;
                default:     occ_q <= OCC_EMPTY;
            endcase

    a_empty_matches: assert property (@(posedge clk) disable iff (!rst) (occ_q == OCC_EMPTY) == (count_q == '0));
    a_full_matches:  assert property (@(posedge clk) disable iff (!rst) (occ_q == OCC_FULL) == (count_q == FULL_CNT));

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed checks of the IF/ID fetch queue
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic [31:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .out_ready(out_ready),
        .count    (count),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = {16'hA5A5, pc[15:0]};
        out_ready = r;
    endtask

    initial begin
        // reset held with a fetch presented
        drive(1'b1, 32'h0, 1'b0);
        in_instr = 32'hFEDCBA98;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        // first push after release
        rst = 1'b1;
        step();
        check("p0_valid", 64'(out_valid), 64'd1);
        check("p0_count", 64'(count), 64'd1);
        check("p0_pc", 64'(out_pc), 64'h0);
        check("p0_instr", 64'(out_instr), 64'hFEDCBA98);
        check("p0_stall", 64'(stall_cnt), 64'd0);
        // fill while ID stalls
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0);
            step();
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_stall", 64'(stall_cnt), 64'(i));
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'd16, 1'b0);
        step();
        check("refused_count", 64'(count), 64'd4);
        check("refused_head", 64'(out_pc), 64'd0);
        check("refused_stall", 64'(stall_cnt), 64'd4);
        // drain in order
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_pc", 64'(out_pc), 64'(4 * i));
            step();
        end
        check("drained_valid", 64'(out_valid), 64'd0);
        check("drained_count", 64'(count), 64'd0);
        check("drained_pc", 64'(out_pc), 64'd0);
        check("drained_stall", 64'(stall_cnt), 64'd4);
        // prime two entries, then stream through the wrap point
        drive(1'b1, 32'h20, 1'b0);
        step();
        drive(1'b1, 32'h24, 1'b0);
        step();
        check("prime_count", 64'(count), 64'd2);
        check("prime_stall", 64'(stall_cnt), 64'd5);
        for (int i = 0; i < 10; i++) begin
            check("wrap_pc", 64'(out_pc), 64'(32'h20 + 4 * i));
            check("wrap_count", 64'(count), 64'd2);
            drive(1'b1, 32'(32'h28 + 4 * i), 1'b1);
            step();
        end
        check("wrap_end_pc", 64'(out_pc), 64'h48);
        check("wrap_end_instr", 64'(out_instr), 64'hA5A50048);
        // third entry, then flush with a push and a pop in the same cycle
        drive(1'b1, 32'h50, 1'b0);
        step();
        check("pre_flush_count", 64'(count), 64'd3);
        check("pre_flush_stall", 64'(stall_cnt), 64'd6);
        drive(1'b1, 32'h40, 1'b1);
        flush = 1'b1;
        step();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_stall", 64'(stall_cnt), 64'd6);
        // flush on an empty queue
        drive(1'b1, 32'h44, 1'b0);
        step();
        check("flush_empty_count", 64'(count), 64'd0);
        check("flush_empty_stall", 64'(stall_cnt), 64'd6);
        flush = 1'b0;
        drive(1'b1, 32'h100, 1'b0);
        step();
        check("post_flush_pc", 64'(out_pc), 64'h100);
        check("post_flush_count", 64'(count), 64'd1);
        // async reset between edges
        drive(1'b1, 32'h104, 1'b0);
        step();
        drive(1'b1, 32'h108, 1'b0);
        step();
        check("pre_areset_count", 64'(count), 64'd3);
        check("pre_areset_stall", 64'(stall_cnt), 64'd8);
        drive(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("areset_valid", 64'(out_valid), 64'd0);
        check("areset_count", 64'(count), 64'd0);
        check("areset_stall", 64'(stall_cnt), 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
